decode_stage: RTL
=================

# decode_stage

Registered RV32I instruction-decode pipeline stage between fetch and register-read/execute. It decodes the full base ISA, and the M extension when enabled, into the codebase's `ALU_*` / `OP_TYPE_*` control encoding. A valid/ready handshake with a 2-entry skid buffer gives full throughput under back-pressure. It adds a flush input, illegal-instruction detection and a configurable halt encoding.

## Interface
- `PC_W`, 32: width of the PC carried alongside each instruction.
- `ENABLE_M`, 0: 1 = decode MUL/DIV/REM (funct7=0000001 under OP); 0 = those encodings are illegal.
- `HALT_INSN`, 32'h00000073: exact 32-bit encoding that raises `is_halt` (ECALL by default).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered and incoming instructions.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage can accept an instruction.
- `in_ir` in 32: machine-code instruction.
- `in_pc` in PC_W: PC of `in_ir`.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: downstream accepts the bundle.
- `out_pc` out PC_W: PC of the decoded instruction.
- `srcreg1_num`, `srcreg2_num`, `dstreg_num` out 5 each: rs1, rs2, rd; 0 when unused by the format.
- `imm` out 32: sign-extended immediate for the format.
- `alucode` out 6: `ALU_*` code.
- `aluop1_type`, `aluop2_type` out 2 each: `OP_TYPE_REG/IMM/PC/NONE`.
- `reg_we`, `is_load`, `is_store`, `is_halt`, `is_illegal` out 1 each.
- `mem_size` out 3: funct3 for LOAD/STORE, else 0.

## Operation
- Formats:
  - U: LUI, AUIPC.
  - J: JAL.
  - I: OPIMM, LOAD, JALR.
  - B: BRANCH.
  - S: STORE.
  - R: OP.
- Register fields by format:
  - rs1 = ir[19:15] for I/B/S/R.
  - rs2 = ir[24:20] for B/S/R.
  - rd = ir[11:7] for U/J/I/R.
  - Every other case is 0.
- Immediates:
  - U: {ir[31:12],12'b0}.
  - J: sext {ir[31],ir[19:12],ir[20],ir[30:21],0}.
  - B: sext {ir[31],ir[7],ir[30:25],ir[11:8],0}.
  - S: sext {ir[31:25],ir[11:7]}.
  - I: sext ir[31:20].
  - I shifts (funct3=001/101): zero-extended shamt ir[24:20].
  - R: 0.
- OPIMM and OP use funct3 for the ALU op. ir[30] selects SRA/SRL, and under OP it also selects SUB/ADD. aluop2 is IMM for OPIMM and REG for OP.
- LUI: op1 NONE, op2 IMM.
- AUIPC: op1 PC, op2 IMM.
- JAL and JALR write rd with PC+4, and alucode carries the jump code.
- BRANCH: alucode = branch compare code, reg_we=0.
- LOAD: ALU_LB..LHU by funct3, is_load=1, reg_we=1.
- STORE: ALU_SB..SW, is_store=1, reg_we=0.
- Illegal: unknown opcode, reserved funct3 in BRANCH/LOAD/STORE, or bad funct7 (including M encodings when ENABLE_M=0).
  - Sets is_illegal=1.
  - Forces reg_we, is_load and is_store to 0.
  - All other fields are don't-care.
- is_halt=1 iff ir == HALT_INSN. Then reg_we=0 and is_illegal=0.
- Buffer has two entries: main (drives outputs) and skid.
  - `in_ready` = skid empty, driven directly from a register.
  - Accept when in_valid && in_ready. The decode result goes to main if main is empty or being drained this cycle, otherwise to skid.
  - When main drains and skid is full, skid moves to main.

## Timing
- Latency: exactly 1 cycle from accept edge to `out_valid` with the decoded fields.
- Throughput: 1 instruction per cycle while out_ready=1.
- Back-pressure:
  - Out fields hold stable while out_valid && !out_ready.
  - At most one extra instruction is absorbed (into skid); in_ready falls the next cycle.
  - in_ready rises the cycle after main drains.
- Order is strictly preserved; no instruction is duplicated or dropped except by flush.
- Flush:
  - Both entries are emptied at that edge, and any input presented that cycle is not accepted.
  - Next cycle: out_valid=0, in_ready=1.
  - Flush overrides a simultaneous accept or drain.
- Reset:
  - Same behaviour as flush, and all output fields are cleared: imm=0, alucode=0, types=0, all flags 0, out_pc=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-stall drops both entries.
- Decoded fields are registered; no output depends combinationally on `in_ir`.

## Test plan
- `addi x5,x1,-3` (32'hFFD08293) at PC 0x100:
  - Next cycle: out_valid=1, rs1=1, rd=5, imm=32'hFFFFFFFD, ALU_ADD, REG/IMM, reg_we=1.
  - out_pc=0x100.
- Stream of 8 instructions with out_ready=1: 8 consecutive out_valid cycles, order and PCs preserved.
- Back-pressure: hold out_ready=0 for 3 cycles while in_valid=1.
  - Instruction A held on outputs; B goes to skid; in_ready=0 after 1 cycle.
  - Release out_ready: A, B, C emerge in order with no bubble or loss.
- Flush while both entries are full and in_valid=1:
  - Next cycle: out_valid=0, in_ready=1.
  - The instruction presented during the flush cycle never appears.
- `mul x3,x1,x2` (32'h022081B3):
  - ENABLE_M=0 gives is_illegal=1, reg_we=0.
  - ENABLE_M=1 gives ALU_MUL, reg_we=1.
- 32'h00000073 gives is_halt=1, reg_we=0. 32'h0000007F gives is_illegal=1.
- Reset asserted mid-stall: all outputs 0 the following cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I(+M) decode pipeline stage: registered decode with a main/skid buffer pair
// so fetch can keep streaming at one instruction per cycle under back-pressure.
module decode_stage #(
  parameter int          PC_W      = 32,
  parameter int          ENABLE_M  = 0,
  parameter logic [31:0] HALT_INSN = 32'h00000073
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      srcreg1_num,
  output logic [4:0]      srcreg2_num,
  output logic [4:0]      dstreg_num,
  output logic [31:0]     imm,
  output logic [5:0]      alucode,
  output logic [1:0]      aluop1_type,
  output logic [1:0]      aluop2_type,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic            is_halt,
  output logic            is_illegal,
  output logic [2:0]      mem_size
);

  localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2,
                         ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5,
                         ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8,
                         ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11,
                         ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14,
                         ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17,
                         ALU_SUB  = 6'd18, ALU_SLL  = 6'd19, ALU_SLT  = 6'd20,
                         ALU_SLTU = 6'd21, ALU_XOR  = 6'd22, ALU_SRL  = 6'd23,
                         ALU_SRA  = 6'd24, ALU_OR   = 6'd25, ALU_AND  = 6'd26,
                         ALU_MUL  = 6'd27, ALU_NOP  = 6'd63;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1,
                         OP_TYPE_IMM  = 2'd2, OP_TYPE_PC  = 2'd3;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        is_illegal;
    logic [2:0]  mem_size;
  } dec_t;

  function automatic logic [5:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    d  = '0;
    case (ir[6:0])
      7'b0110111: begin  // LUI
        d.rd = ir[11:7]; d.imm = {ir[31:12], 12'b0}; d.alucode = ALU_LUI;
        d.op1 = OP_TYPE_NONE; d.op2 = OP_TYPE_IMM; d.reg_we = 1'b1;
      end
      7'b0010111: begin  // AUIPC
        d.rd = ir[11:7]; d.imm = {ir[31:12], 12'b0}; d.alucode = ALU_ADD;
        d.op1 = OP_TYPE_PC; d.op2 = OP_TYPE_IMM; d.reg_we = 1'b1;
      end
      7'b1101111: begin  // JAL
        d.rd = ir[11:7]; d.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        d.alucode = ALU_JAL; d.op1 = OP_TYPE_PC; d.op2 = OP_TYPE_IMM; d.reg_we = 1'b1;
      end
      7'b1100111: begin  // JALR
        d.rs1 = ir[19:15]; d.rd = ir[11:7]; d.imm = {{20{ir[31]}}, ir[31:20]};
        d.alucode = ALU_JALR; d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_IMM; d.reg_we = 1'b1;
      end
      7'b1100011: begin  // BRANCH
        d.rs1 = ir[19:15]; d.rs2 = ir[24:20];
        d.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_REG;
        case (f3)
          3'b000:  d.alucode = ALU_BEQ;
          3'b001:  d.alucode = ALU_BNE;
          3'b100:  d.alucode = ALU_BLT;
          3'b101:  d.alucode = ALU_BGE;
          3'b110:  d.alucode = ALU_BLTU;
          3'b111:  d.alucode = ALU_BGEU;
          default: d.is_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin  // LOAD
        d.rs1 = ir[19:15]; d.rd = ir[11:7]; d.imm = {{20{ir[31]}}, ir[31:20]};
        d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_IMM; d.reg_we = 1'b1; d.is_load = 1'b1;
        d.mem_size = f3;
        case (f3)
          3'b000:  d.alucode = ALU_LB;
          3'b001:  d.alucode = ALU_LH;
          3'b010:  d.alucode = ALU_LW;
          3'b100:  d.alucode = ALU_LBU;
          3'b101:  d.alucode = ALU_LHU;
          default: d.is_illegal = 1'b1;
        endcase
      end
      7'b0100011: begin  // STORE
        d.rs1 = ir[19:15]; d.rs2 = ir[24:20]; d.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_IMM; d.is_store = 1'b1; d.mem_size = f3;
        case (f3)
          3'b000:  d.alucode = ALU_SB;
          3'b001:  d.alucode = ALU_SH;
          3'b010:  d.alucode = ALU_SW;
          default: d.is_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin  // OPIMM; shifts carry a zero-extended shamt
        d.rs1 = ir[19:15]; d.rd = ir[11:7]; d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_IMM;
        d.reg_we = 1'b1; d.alucode = alu_base(f3, ir[30]);
        if (f3 == 3'b001 || f3 == 3'b101) d.imm = {27'b0, ir[24:20]};
        else                              d.imm = {{20{ir[31]}}, ir[31:20]};
        if (f3 == 3'b001 && f7 != 7'b0000000) d.is_illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) d.is_illegal = 1'b1;
      end
      7'b0110011: begin  // OP
        d.rs1 = ir[19:15]; d.rs2 = ir[24:20]; d.rd = ir[11:7];
        d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_REG; d.reg_we = 1'b1;
        case (f7)
          7'b0000000: d.alucode = alu_base(f3, 1'b0);
          7'b0100000: begin
            if (f3 == 3'b000)      d.alucode = ALU_SUB;
            else if (f3 == 3'b101) d.alucode = ALU_SRA;
            else                   d.is_illegal = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M != 0) d.alucode = ALU_MUL + {3'b000, f3};
            else               d.is_illegal = 1'b1;
          end
          default: d.is_illegal = 1'b1;
        endcase
      end
      7'b0001111, 7'b1110011: d.alucode = ALU_NOP;  // FENCE / SYSTEM: no architectural effect here
      default: d.is_illegal = 1'b1;
    endcase
    if (d.is_illegal) begin
      d.reg_we = 1'b0; d.is_load = 1'b0; d.is_store = 1'b0;
    end
    if (ir == HALT_INSN) begin
      d.is_halt = 1'b1; d.reg_we = 1'b0; d.is_illegal = 1'b0;
    end
    return d;
  endfunction

  dec_t            dec_in, main_q, skid_q;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic            main_valid, skid_empty;

  always_comb dec_in = decode(in_ir);

  // skid_empty is kept as its own register so in_ready is a pure flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_empty <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_empty <= 1'b1;
    end else if (!main_valid || out_ready) begin
      if (!skid_empty) begin
        main_q     <= skid_q;
        main_pc    <= skid_pc;
        main_valid <= 1'b1;
        skid_empty <= 1'b1;
      end else if (in_valid) begin
        main_q     <= dec_in;
        main_pc    <= in_pc;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_valid && skid_empty) begin
      skid_q     <= dec_in;
      skid_pc    <= in_pc;
      skid_empty <= 1'b0;
    end
  end

  assign in_ready    = skid_empty;
  assign out_valid   = main_valid;
  assign out_pc      = main_pc;
  assign srcreg1_num = main_q.rs1;
  assign srcreg2_num = main_q.rs2;
  assign dstreg_num  = main_q.rd;
  assign imm         = main_q.imm;
  assign alucode     = main_q.alucode;
  assign aluop1_type = main_q.op1;
  assign aluop2_type = main_q.op2;
  assign reg_we      = main_q.reg_we;
  assign is_load     = main_q.is_load;
  assign is_store    = main_q.is_store;
  assign is_halt     = main_q.is_halt;
  assign is_illegal  = main_q.is_illegal;
  assign mem_size    = main_q.mem_size;

endmodule
